// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - RV32I multicycle control decoder with load/store sequencing and sticky halt
// Optional M-extension handshake (muldiv_start/muldiv_done) is built when CTRL_MULDIV_EN is defined.
module multicycle_control_unit #(
  parameter int LOAD_LATENCY  = 1,
  parameter int STORE_LATENCY = 0,
  parameter int CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [1:0]  addr_lo,
`ifdef CTRL_MULDIV_EN
  output logic        muldiv_start,
  input  logic        muldiv_done,
`endif
  output logic        reg_write_en,
  output logic        alu_srcA,
  output logic        alu_srcB,
  output logic [1:0]  dest_reg_sel,
  output logic [3:0]  alu_op,
  output logic [3:0]  mem_write_en,
  output logic        read_enable,
  output logic        pc_stall,
  output logic        halt,
  output logic        halt_now,
  output logic        illegal_instr
);

  localparam logic [2:0] ST_RUN        = 3'd0;
  localparam logic [2:0] ST_LOAD_WAIT  = 3'd1;
  localparam logic [2:0] ST_STORE_WAIT = 3'd2;
  localparam logic [2:0] ST_HALTED     = 3'd3;
`ifdef CTRL_MULDIV_EN
  localparam logic [2:0] ST_MULDIV_WAIT = 3'd4;
`endif

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OPIMM = 7'b0010011, OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_FENCE = 7'b0001111, OPC_SYSTEM = 7'b1110011;

  localparam logic [CNT_W-1:0] LD_INIT = (LOAD_LATENCY > 0) ? CNT_W'(LOAD_LATENCY - 1) : '0;
  localparam logic [CNT_W-1:0] ST_INIT = (STORE_LATENCY > 0) ? CNT_W'(STORE_LATENCY - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]       r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt, w_next_cnt;
  logic             r_halt, r_illegal, w_set_illegal;
  logic [6:0]       w_opcode, w_funct7;
  logic [2:0]       w_funct3;
  logic             w_bad, w_sys_halt, w_is_load, w_is_store, w_misaligned;
  logic             w_dec_wr, w_dec_srcA, w_dec_srcB;
  logic [1:0]       w_dec_wb;
  logic [3:0]       w_dec_alu, w_mask;
`ifdef CTRL_MULDIV_EN
  logic             w_is_muldiv;
`endif

  assign w_opcode      = instruction[6:0];
  assign w_funct3      = instruction[14:12];
  assign w_funct7      = instruction[31:25];
  assign halt          = r_halt;
  assign illegal_instr = r_illegal;

  function automatic logic [3:0] f3_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_alu = ALU_ADD;
      3'b001:  f3_alu = ALU_SLL;
      3'b010:  f3_alu = ALU_SLT;
      3'b011:  f3_alu = ALU_SLTU;
      3'b100:  f3_alu = ALU_XOR;
      3'b101:  f3_alu = ALU_SRL;
      3'b110:  f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  endfunction

  always_comb begin
    w_bad = 1'b0; w_sys_halt = 1'b0; w_is_load = 1'b0; w_is_store = 1'b0; w_misaligned = 1'b0;
    w_dec_wr = 1'b0; w_dec_srcA = 1'b0; w_dec_srcB = 1'b0; w_dec_wb = 2'd0;
    w_dec_alu = ALU_ADD; w_mask = 4'b0000;
`ifdef CTRL_MULDIV_EN
    w_is_muldiv = 1'b0;
`endif
    case (w_opcode)
      OPC_OP: begin
        w_dec_wr = 1'b1;
        if (w_funct7 == 7'b0000000) w_dec_alu = f3_alu(w_funct3);
        else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) w_dec_alu = ALU_SUB;
        else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101) w_dec_alu = ALU_SRA;
        else if (w_funct7 == 7'b0000001) begin
`ifdef CTRL_MULDIV_EN
          w_dec_wr    = 1'b0;
          w_is_muldiv = 1'b1;
`else
          w_bad = 1'b1;
`endif
        end else w_bad = 1'b1;
      end
      OPC_OPIMM: begin
        w_dec_wr = 1'b1; w_dec_srcB = 1'b1; w_dec_alu = f3_alu(w_funct3);
        if (w_funct3 == 3'b001 && w_funct7 != 7'b0000000) w_bad = 1'b1;
        if (w_funct3 == 3'b101) begin
          if (w_funct7 == 7'b0100000) w_dec_alu = ALU_SRA;
          else if (w_funct7 != 7'b0000000) w_bad = 1'b1;
        end
      end
      OPC_LUI:   begin w_dec_wr = 1'b1; w_dec_srcB = 1'b1; w_dec_alu = ALU_PASSB; end
      OPC_AUIPC: begin w_dec_wr = 1'b1; w_dec_srcA = 1'b1; w_dec_srcB = 1'b1; end
      OPC_JAL:   begin w_dec_wr = 1'b1; w_dec_srcA = 1'b1; w_dec_srcB = 1'b1; w_dec_wb = 2'd2; end
      OPC_JALR: begin
        w_dec_wr = 1'b1; w_dec_srcB = 1'b1; w_dec_wb = 2'd2;
        if (w_funct3 != 3'b000) w_bad = 1'b1;
      end
      OPC_BRANCH: begin
        case (w_funct3)
          3'b000, 3'b001: w_dec_alu = ALU_SUB;
          3'b100, 3'b101: w_dec_alu = ALU_SLT;
          3'b110, 3'b111: w_dec_alu = ALU_SLTU;
          default:        w_bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_is_load = 1'b1; w_dec_srcB = 1'b1; w_dec_wb = 2'd1;
        case (w_funct3)
          3'b000, 3'b100: w_misaligned = 1'b0;
          3'b001, 3'b101: w_misaligned = addr_lo[0];
          3'b010:         w_misaligned = (addr_lo != 2'd0);
          default:        w_bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        w_is_store = 1'b1; w_dec_srcB = 1'b1;
        case (w_funct3)
          3'b000: w_mask = 4'b0001 << addr_lo;
          3'b001: begin w_mask = 4'b0011 << addr_lo; w_misaligned = addr_lo[0]; end
          3'b010: begin w_mask = 4'b1111; w_misaligned = (addr_lo != 2'd0); end
          default: w_bad = 1'b1;
        endcase
      end
      OPC_FENCE: w_bad = 1'b0;
      OPC_SYSTEM: begin
        if (instruction == 32'h0000_0073 || instruction == 32'h0010_0073) w_sys_halt = 1'b1;
        else w_bad = 1'b1;
      end
      default: w_bad = 1'b1;
    endcase
  end

  // Reset forces every strobe inactive; the wait states keep the decoded address path live.
  always_comb begin
    reg_write_en = 1'b0; alu_srcA = 1'b0; alu_srcB = 1'b0; dest_reg_sel = 2'd0;
    alu_op = ALU_ADD; mem_write_en = 4'b0000; read_enable = 1'b0; pc_stall = 1'b0;
    halt_now = 1'b0; w_set_illegal = 1'b0; w_next_state = r_state; w_next_cnt = r_cnt;
`ifdef CTRL_MULDIV_EN
    muldiv_start = 1'b0;
`endif
    if (!rst) begin
      pc_stall = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_bad || w_misaligned || w_sys_halt) begin
            halt_now      = 1'b1;
            pc_stall      = 1'b1;
            w_set_illegal = w_bad || w_misaligned;
            w_next_state  = ST_HALTED;
          end else begin
            alu_op = w_dec_alu; alu_srcA = w_dec_srcA; alu_srcB = w_dec_srcB; dest_reg_sel = w_dec_wb;
            if (w_is_load) begin
              read_enable = 1'b1;
              if (LOAD_LATENCY == 0) reg_write_en = 1'b1;
              else begin
                pc_stall = 1'b1; w_next_state = ST_LOAD_WAIT; w_next_cnt = LD_INIT;
              end
            end else if (w_is_store) begin
              mem_write_en = w_mask;
              if (STORE_LATENCY != 0) begin
                pc_stall = 1'b1; w_next_state = ST_STORE_WAIT; w_next_cnt = ST_INIT;
              end
            end
`ifdef CTRL_MULDIV_EN
            else if (w_is_muldiv) begin
              muldiv_start = 1'b1;
              if (muldiv_done) begin
                reg_write_en = 1'b1; dest_reg_sel = 2'd3;
              end else begin
                pc_stall = 1'b1; w_next_state = ST_MULDIV_WAIT;
              end
            end
`endif
            else reg_write_en = w_dec_wr;
          end
        end
        ST_LOAD_WAIT: begin
          alu_op = w_dec_alu; alu_srcB = w_dec_srcB; dest_reg_sel = 2'd1; read_enable = 1'b1;
          if (r_cnt == '0) begin
            reg_write_en = 1'b1; w_next_state = ST_RUN;
          end else begin
            pc_stall = 1'b1; w_next_cnt = r_cnt - CNT_ONE;
          end
        end
        ST_STORE_WAIT: begin
          alu_op = w_dec_alu; alu_srcB = w_dec_srcB;
          if (r_cnt == '0) w_next_state = ST_RUN;
          else begin
            pc_stall = 1'b1; w_next_cnt = r_cnt - CNT_ONE;
          end
        end
`ifdef CTRL_MULDIV_EN
        ST_MULDIV_WAIT: begin
          if (muldiv_done) begin
            reg_write_en = 1'b1; dest_reg_sel = 2'd3; w_next_state = ST_RUN;
          end else pc_stall = 1'b1;
        end
`endif
        default: begin
          pc_stall     = 1'b1;
          w_next_state = ST_HALTED;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_RUN;
      r_cnt     <= '0;
      r_halt    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (halt_now) r_halt <= 1'b1;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed bench for multicycle_control_unit (load 3 / store 2 and load 0 / store 0 builds)
module tb_multicycle_control_unit;

  localparam logic [31:0] I_ADD = 32'h003100B3, I_LW = 32'h0000A083, I_LH = 32'h00009083;
  localparam logic [31:0] I_SB = 32'h00208023, I_SH = 32'h00209023, I_SW = 32'h0020A023;
  localparam logic [31:0] I_ECALL = 32'h00000073, I_EBREAK = 32'h00100073, I_MUL = 32'h023100B3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instruction = I_ADD;
  logic [1:0]  addr_lo = 2'd0;
  logic        muldiv_done = 1'b0;
  logic        muldiv_start, z_muldiv_start;

  logic        reg_write_en, alu_srcA, alu_srcB, read_enable, pc_stall, halt, halt_now, illegal_instr;
  logic [1:0]  dest_reg_sel;
  logic [3:0]  alu_op, mem_write_en;
  logic        z_reg_write_en, z_alu_srcA, z_alu_srcB, z_read_enable, z_pc_stall, z_halt, z_halt_now;
  logic        z_illegal_instr;
  logic [1:0]  z_dest_reg_sel;
  logic [3:0]  z_alu_op, z_mem_write_en;

  logic [9:0]  st, st0;
  int          checks = 0;
  int          errors = 0;

  assign st  = {reg_write_en, read_enable, pc_stall, halt_now, halt, illegal_instr, mem_write_en};
  assign st0 = {z_reg_write_en, z_read_enable, z_pc_stall, z_halt_now, z_halt, z_illegal_instr,
                z_mem_write_en};

  always #5 clk = ~clk;

  multicycle_control_unit #(.LOAD_LATENCY(3), .STORE_LATENCY(2), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .instruction(instruction), .addr_lo(addr_lo),
`ifdef CTRL_MULDIV_EN
    .muldiv_start(muldiv_start), .muldiv_done(muldiv_done),
`endif
    .reg_write_en(reg_write_en), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
    .dest_reg_sel(dest_reg_sel), .alu_op(alu_op), .mem_write_en(mem_write_en),
    .read_enable(read_enable), .pc_stall(pc_stall), .halt(halt), .halt_now(halt_now),
    .illegal_instr(illegal_instr)
  );

  multicycle_control_unit #(.LOAD_LATENCY(0), .STORE_LATENCY(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .instruction(instruction), .addr_lo(addr_lo),
`ifdef CTRL_MULDIV_EN
    .muldiv_start(z_muldiv_start), .muldiv_done(muldiv_done),
`endif
    .reg_write_en(z_reg_write_en), .alu_srcA(z_alu_srcA), .alu_srcB(z_alu_srcB),
    .dest_reg_sel(z_dest_reg_sel), .alu_op(z_alu_op), .mem_write_en(z_mem_write_en),
    .read_enable(z_read_enable), .pc_stall(z_pc_stall), .halt(z_halt), .halt_now(z_halt_now),
    .illegal_instr(z_illegal_instr)
  );

`ifndef CTRL_MULDIV_EN
  assign muldiv_start   = 1'b0;
  assign z_muldiv_start = 1'b0;
`endif

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; instruction = I_ADD; addr_lo = 2'd0;
    for (int c = 0; c < 2; c++) begin
      next_cycle(); #2;
      checks++;
      if (st !== 10'b0010000000) begin
        errors++; $display("FAIL reset_hold st=%b exp=%b", st, 10'b0010000000);
      end
      checks++;
      if ({alu_op, alu_srcA, alu_srcB, dest_reg_sel} !== 8'h00) begin
        errors++; $display("FAIL reset_hold_sel got=%h exp=00", {alu_op, alu_srcA, alu_srcB, dest_reg_sel});
      end
    end
    rst = 1'b1; #2;
    checks++;
    if (st !== 10'b1000000000) begin
      errors++; $display("FAIL reset_release st=%b exp=%b", st, 10'b1000000000);
    end
    checks++;
    if ({alu_op, alu_srcA, alu_srcB, dest_reg_sel} !== 8'h00) begin
      errors++; $display("FAIL reset_release_sel got=%h exp=00", {alu_op, alu_srcA, alu_srcB, dest_reg_sel});
    end
  endtask

  task automatic test_decode();
    logic [31:0] ins [14];
    logic [9:0]  exp [14];
    logic [9:0]  got;
    // expected {alu_op, srcA, srcB, wb, reg_write_en, pc_stall}
    ins[0]  = 32'h403100B3; exp[0]  = 10'b0001_0_0_00_1_0;
    ins[1]  = 32'h403150B3; exp[1]  = 10'b0111_0_0_00_1_0;
    ins[2]  = 32'h40315093; exp[2]  = 10'b0111_0_1_00_1_0;
    ins[3]  = 32'h00510093; exp[3]  = 10'b0000_0_1_00_1_0;
    ins[4]  = 32'h00113093; exp[4]  = 10'b0100_0_1_00_1_0;
    ins[5]  = 32'h123450B7; exp[5]  = 10'b1010_0_1_00_1_0;
    ins[6]  = 32'h00000097; exp[6]  = 10'b0000_1_1_00_1_0;
    ins[7]  = 32'h000000EF; exp[7]  = 10'b0000_1_1_10_1_0;
    ins[8]  = 32'h000100E7; exp[8]  = 10'b0000_0_1_10_1_0;
    ins[9]  = 32'h0020C063; exp[9]  = 10'b0011_0_0_00_0_0;
    ins[10] = 32'h0020F063; exp[10] = 10'b0100_0_0_00_0_0;
    ins[11] = 32'h00209063; exp[11] = 10'b0001_0_0_00_0_0;
    ins[12] = 32'h003170B3; exp[12] = 10'b1001_0_0_00_1_0;
    ins[13] = 32'h0000000F; exp[13] = 10'b0000_0_0_00_0_0;
    for (int i = 0; i < 14; i++) begin
      next_cycle(); instruction = ins[i]; addr_lo = 2'd0; #2;
      got = {alu_op, alu_srcA, alu_srcB, dest_reg_sel, reg_write_en, pc_stall};
      checks++;
      if (got !== exp[i] || halt_now !== 1'b0) begin
        errors++; $display("FAIL decode_%0d instr=%h got=%b halt_now=%b exp=%b", i, ins[i], got, halt_now, exp[i]);
      end
    end
  endtask

  task automatic test_load();
    logic [9:0] e;
    next_cycle(); instruction = I_LW; addr_lo = 2'd0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) next_cycle();
      #2;
      e = {(c == 4), 1'b1, (c < 4), 7'b0};
      checks++;
      if (st !== e) begin
        errors++; $display("FAIL load_cycle%0d st=%b exp=%b", c, st, e);
      end
      if (c == 4) begin
        checks++;
        if (dest_reg_sel !== 2'd1) begin
          errors++; $display("FAIL load_wb got=%0d exp=1", dest_reg_sel);
        end
      end
      if (c == 1) begin
        checks++;
        if (st0 !== 10'b1100000000 || z_dest_reg_sel !== 2'd1) begin
          errors++; $display("FAIL load_lat0 st=%b wb=%0d exp=1100000000 wb=1", st0, z_dest_reg_sel);
        end
      end
    end
    next_cycle(); instruction = I_ADD; #2;
    checks++;
    if (st !== 10'b1000000000) begin
      errors++; $display("FAIL load_resume st=%b exp=1000000000", st);
    end
    next_cycle(); instruction = I_LW; #2;
    next_cycle(); rst = 1'b0; #2;
    checks++;
    if (st !== 10'b0010000000) begin
      errors++; $display("FAIL load_abort st=%b exp=0010000000", st);
    end
    next_cycle(); rst = 1'b1; instruction = I_ADD; #2;
    checks++;
    if (st !== 10'b1000000000) begin
      errors++; $display("FAIL load_after_abort st=%b exp=1000000000", st);
    end
  endtask

  task automatic test_stores();
    logic [31:0] ins [3];
    logic [1:0]  al  [3];
    logic [3:0]  msk [3];
    logic [9:0]  e;
    ins[0] = I_SB; al[0] = 2'd2; msk[0] = 4'b0100;
    ins[1] = I_SW; al[1] = 2'd0; msk[1] = 4'b1111;
    ins[2] = I_SH; al[2] = 2'd2; msk[2] = 4'b1100;
    for (int s = 0; s < 3; s++) begin
      next_cycle(); instruction = ins[s]; addr_lo = al[s];
      for (int c = 1; c <= 3; c++) begin
        if (c > 1) next_cycle();
        #2;
        e = {2'b00, (c < 3), 3'b000, (c == 1) ? msk[s] : 4'b0000};
        checks++;
        if (st !== e) begin
          errors++; $display("FAIL store%0d_cycle%0d st=%b exp=%b", s, c, st, e);
        end
        if (c == 1) begin
          checks++;
          if (st0 !== {6'b000000, msk[s]}) begin
            errors++; $display("FAIL store%0d_lat0 st=%b exp=%b", s, st0, {6'b000000, msk[s]});
          end
        end
      end
    end
    next_cycle(); instruction = I_ADD; addr_lo = 2'd0; #2;
    checks++;
    if (st !== 10'b1000000000) begin
      errors++; $display("FAIL store_resume st=%b exp=1000000000", st);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins [5];
    logic [1:0]  al  [5];
    ins[0] = I_SH;          al[0] = 2'd1;
    ins[1] = I_LW;          al[1] = 2'd2;
    ins[2] = I_LH;          al[2] = 2'd1;
    ins[3] = 32'h403110B3;  al[3] = 2'd0;
    ins[4] = 32'h0000007F;  al[4] = 2'd0;
    for (int i = 0; i < 5; i++) begin
      do_reset(); instruction = ins[i]; addr_lo = al[i]; #2;
      checks++;
      if ({reg_write_en, read_enable, halt_now, halt, illegal_instr, mem_write_en} !== 9'b001000000 ||
          {z_reg_write_en, z_read_enable, z_halt_now, z_mem_write_en} !== 7'b0010000) begin
        errors++; $display("FAIL illegal%0d_issue st=%b st0=%b exp halt_now only", i, st, st0);
      end
      next_cycle(); instruction = I_ADD; addr_lo = 2'd0; #2;
      checks++;
      if (st !== 10'b0010110000 || st0 !== 10'b0010110000) begin
        errors++; $display("FAIL illegal%0d_sticky st=%b st0=%b exp=0010110000", i, st, st0);
      end
    end
  endtask

  task automatic test_halt();
    logic [31:0] ins [3];
    ins[0] = I_ADD; ins[1] = 32'hFFFFFFFF; ins[2] = I_ECALL;
    do_reset(); instruction = I_ECALL; addr_lo = 2'd0; #2;
    checks++;
    if ({reg_write_en, halt_now, halt, illegal_instr} !== 4'b0100) begin
      errors++; $display("FAIL ecall_issue got=%b exp=0100", {reg_write_en, halt_now, halt, illegal_instr});
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle(); instruction = ins[i]; #2;
      checks++;
      if (st !== 10'b0010100000) begin
        errors++; $display("FAIL halted%0d st=%b exp=0010100000", i, st);
      end
    end
    do_reset(); instruction = I_ADD; #2;
    checks++;
    if (st !== 10'b1000000000) begin
      errors++; $display("FAIL halt_cleared st=%b exp=1000000000", st);
    end
    next_cycle(); instruction = I_EBREAK; #2;
    checks++;
    if ({halt_now, illegal_instr, reg_write_en} !== 3'b100) begin
      errors++; $display("FAIL ebreak got=%b exp=100", {halt_now, illegal_instr, reg_write_en});
    end
  endtask

  task automatic test_muldiv();
    int starts;
    do_reset(); muldiv_done = 1'b0; instruction = I_MUL; addr_lo = 2'd0; #2;
`ifdef CTRL_MULDIV_EN
    starts = 0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) next_cycle();
      #2;
      if (muldiv_start === 1'b1) starts++;
      checks++;
      if ({reg_write_en, pc_stall, halt_now} !== 3'b010) begin
        errors++; $display("FAIL muldiv_wait%0d got=%b exp=010", c, {reg_write_en, pc_stall, halt_now});
      end
    end
    next_cycle(); muldiv_done = 1'b1; #2;
    if (muldiv_start === 1'b1) starts++;
    checks++;
    if ({reg_write_en, pc_stall, dest_reg_sel} !== 4'b1011) begin
      errors++; $display("FAIL muldiv_done got=%b exp=1011", {reg_write_en, pc_stall, dest_reg_sel});
    end
    checks++;
    if (starts !== 1) begin
      errors++; $display("FAIL muldiv_start_pulses got=%0d exp=1", starts);
    end
    next_cycle(); #2;
    checks++;
    if ({muldiv_start, reg_write_en, pc_stall, dest_reg_sel} !== 5'b11011) begin
      errors++; $display("FAIL muldiv_same_cycle got=%b exp=11011", {muldiv_start, reg_write_en, pc_stall, dest_reg_sel});
    end
    muldiv_done = 1'b0;
`else
    starts = 0;
    checks++;
    if ({halt_now, reg_write_en, muldiv_start} !== 3'b100) begin
      errors++; $display("FAIL mul_illegal_issue got=%b exp=100", {halt_now, reg_write_en, muldiv_start});
    end
    next_cycle(); instruction = I_ADD; #2;
    checks++;
    if ({halt, illegal_instr, reg_write_en} !== 3'b110) begin
      errors++; $display("FAIL mul_illegal_sticky got=%b exp=110 starts=%0d", {halt, illegal_instr, reg_write_en}, starts);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_decode();
    test_load();
    test_stores();
    test_illegal();
    test_halt();
    test_muldiv();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
